// File: rtl/rv_mem_pkg.sv
// Shared constants for the RV load/store unit: funct3 codes, FSM state
// encodings and an access-size helper.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Legacy-compatible state encodings; the enum mirrors them for debug views.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUS   = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_BUS   = S_BUS,
    ST_RESP  = S_RESP,
    ST_FAULT = S_FAULT
  } mem_state_t;

  // Access size in bytes; funct3[1:0] encodes log2 of the size.
  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

endpackage

// File: rtl/rv_mem_if.sv
// Handshaked memory bus between the load/store unit (master) and memory (slave).
interface rv_mem_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                mem_valid;
  logic                mem_ready;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_adr;
  logic [XLEN-1:0]     mem_wdata;
  logic [XLEN/8-1:0]   mem_be;
  logic [XLEN-1:0]     mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_adr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_adr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/rv_lane_align.sv
// Combinational lane logic: byte enables, store shifting, load extraction
// with sign/zero extension, and legality/alignment of the access.
module rv_lane_align
  import rv_mem_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int BE_W  = XLEN / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  input  logic [2:0]      funct3,
  input  logic            we,
  input  logic [2:0]      adr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata_sh,
  output logic [XLEN-1:0] rdata_ext,
  output logic            legal,
  output logic            aligned
);

  logic [OFF_W-1:0] off;
  logic [BE_W-1:0]  bmask;
  logic [XLEN-1:0]  dmask;
  logic [XLEN-1:0]  rsh;

  assign off = adr_lo[OFF_W-1:0];

  // Size masks, then shift into the lanes selected by the byte offset.
  always_comb begin
    bmask = '1;
    dmask = '1;
    case (funct3[1:0])
      2'b00: begin bmask = BE_W'(1'b1);   dmask = XLEN'(8'hFF);        end
      2'b01: begin bmask = BE_W'(2'b11);  dmask = XLEN'(16'hFFFF);     end
      2'b10: begin bmask = BE_W'(4'hF);   dmask = XLEN'(32'hFFFF_FFFF); end
      default: ;
    endcase
    be       = bmask << off;
    wdata_sh = (wdata & dmask) << {off, 3'b000};
    rsh      = rdata >> {off, 3'b000};
  end

  // Extract the addressed lanes and extend to XLEN.
  always_comb begin
    rdata_ext = rsh;
    case (funct3)
      F3_B:  rdata_ext = XLEN'($signed(rsh[7:0]));
      F3_H:  rdata_ext = XLEN'($signed(rsh[15:0]));
      F3_W:  rdata_ext = XLEN'($signed(rsh[31:0]));
      F3_BU: rdata_ext = XLEN'(rsh[7:0]);
      F3_HU: rdata_ext = XLEN'(rsh[15:0]);
      F3_WU: rdata_ext = XLEN'(rsh[31:0]);
      default: ;
    endcase
  end

  // Doubleword and LWU exist only on a 64-bit datapath; unsigned codes are loads only.
  always_comb begin
    legal = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !we;
      F3_D:             legal = (XLEN == 64);
      F3_WU:            legal = (XLEN == 64) && !we;
      default:          legal = 1'b0;
    endcase
    aligned = (adr_lo & 3'(size_bytes(funct3) - 4'd1)) == 3'd0;
  end

endmodule

// File: rtl/rv_mem_interface.sv
// Load/store unit: accepts one core access at a time, runs it over the
// valid/ready bus with a timeout, and returns a one-cycle done/fault pulse.
module rv_mem_interface
  import rv_mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [XLEN-1:0]   cpu_wdata,
  input  logic [2:0]        cpu_funct3,
  output logic [XLEN-1:0]   cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_fault,
  output logic              cpu_stall,
  rv_mem_if.master          bus
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [2:0]       lo_q;
  logic             we_q;
  logic [XLEN-1:0]  rdata_q;
  logic             idle;
  logic             to_hit;

  logic [2:0]       al_f3;
  logic [2:0]       al_lo;
  logic             al_we;
  logic [BE_W-1:0]  al_be;
  logic [XLEN-1:0]  al_wd;
  logic [XLEN-1:0]  al_rd;
  logic             al_legal;
  logic             al_aligned;

  assign idle = (state == S_IDLE);

  // One lane aligner serves both phases: live core inputs while deciding in
  // IDLE, latched access attributes while extracting load data in BUS.
  assign al_f3 = idle ? cpu_funct3  : f3_q;
  assign al_lo = idle ? cpu_adr[2:0] : lo_q;
  assign al_we = idle ? cpu_we       : we_q;

  rv_lane_align #(.XLEN(XLEN)) u_align (
    .funct3    (al_f3),
    .we        (al_we),
    .adr_lo    (al_lo),
    .wdata     (cpu_wdata),
    .rdata     (bus.mem_rdata),
    .be        (al_be),
    .wdata_sh  (al_wd),
    .rdata_ext (al_rd),
    .legal     (al_legal),
    .aligned   (al_aligned)
  );

  // Terminal count: this BUS cycle without ready is the TIMEOUT-th one.
  assign to_hit = (TIMEOUT > 0) && (32'(cnt) == 32'(TIMEOUT - 1));

  // Access FSM with bus request registers and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      f3_q          <= '0;
      lo_q          <= '0;
      we_q          <= 1'b0;
      rdata_q       <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_adr   <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
    end else begin
      case (state)
        S_IDLE: if (cpu_req) begin
          f3_q <= cpu_funct3;
          lo_q <= cpu_adr[2:0];
          we_q <= cpu_we;
          cnt  <= '0;
          if (al_legal && al_aligned) begin
            state         <= S_BUS;
            bus.mem_we    <= cpu_we;
            bus.mem_adr   <= {cpu_adr[ADDR_W-1:OFF_W], OFF_W'(0)};
            bus.mem_wdata <= al_wd;
            bus.mem_be    <= al_be;
          end else begin
            state <= S_FAULT;
          end
        end
        S_BUS: begin
          // Ready in the terminal-count cycle still completes normally.
          if (bus.mem_ready) begin
            rdata_q <= we_q ? '0 : al_rd;
            state   <= S_RESP;
          end else if (to_hit) begin
            state <= S_FAULT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_valid = (state == S_BUS);
  assign cpu_done      = (state == S_RESP) || (state == S_FAULT);
  assign cpu_fault     = (state == S_FAULT);
  assign cpu_rdata     = cpu_fault ? '0 : rdata_q;
  assign cpu_stall     = (idle && cpu_req) || (state == S_BUS);

endmodule
